// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH/DECODE/MEM/WB sequencing with a run
// gate, mem_ready handshake and timeout, HALT, illegal-opcode flag and retire counter.
module multicycle_control #(
  parameter int OP_W        = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [OP_W-1:0]  instructions,
  input  logic             mem_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic             next_ins,
  output logic             immediate,
  output logic             reg_write,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             mem_req,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [OP_W-1:0] OP_MOV = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LD  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ST  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(7);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ill_q, ill_d;
  logic              mto_q, mto_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      mto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      mto_q   <= mto_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    ill_d      = ill_q;
    mto_d      = mto_q;
    next_ins   = 1'b0;
    immediate  = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_req    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        next_ins = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        // immediate looks at the live opcode here; everywhere else strobes use op_q
        immediate = (instructions == OP_MOV);
        op_d      = instructions;
        wait_d    = '0;
        if (instructions == OP_LD || instructions == OP_ST) state_d = S_MEM;
        else if (instructions == OP_HLT)                     state_d = S_HALT;
        else                                                 state_d = S_WB;
        if (instructions > OP_HLT) ill_d = 1'b1;
      end
      S_MEM: begin
        mem_req    = 1'b1;
        mem_write  = (op_q == OP_ST);
        mem_to_reg = (op_q == OP_LD);
        if (mem_ready) begin
          wait_d  = '0;
          state_d = S_WB;
        end else if (MEM_TIMEOUT > 0 && wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          wait_d  = '0;
          mto_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = (op_q <= OP_MOV) || (op_q == OP_LD);
        immediate  = (op_q == OP_MOV);
        mem_to_reg = (op_q == OP_LD);
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_op      = op_q;
  assign illegal_op  = ill_q;
  assign mem_timeout = mto_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised successor to the 4-state processor control FSM.
- Sequences each instruction through FETCH, DECODE, optional MEM and WB states, and drives the datapath strobes (next_ins, immediate, reg_write, mem_write, mem_to_reg, alu_op).
- Adds what the old FSM lacks: asynchronous reset, a run/idle gate, a mem_ready handshake with a timeout, a HALT opcode, an illegal-opcode flag and a retired-instruction counter.
- Sits between the instruction memory / program counter and the register file, ALU and data memory.

Parameters:
OP_W, 3, opcode width (>=3); opcodes >= 8 are illegal.
MEM_TIMEOUT, 15, max cycles waiting for mem_ready in MEM; 0 disables the timeout.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clock  input  1  system clock, all state updates on posedge.
reset  input  1  asynchronous, active-high; forces IDLE.
run  input  1  level; 1 = keep executing, 0 = park in IDLE after the current instruction.
instructions  input  OP_W  opcode from instruction memory, valid during DECODE.
mem_ready  input  1  data memory completed the access (sampled in MEM).
alu_op  output  OP_W  latched opcode (op_q).
next_ins  output  1  advance PC / fetch strobe.
immediate  output  1  select immediate operand.
reg_write  output  1  register file write enable.
mem_write  output  1  data memory write enable.
mem_to_reg  output  1  write-back mux selects memory data.
mem_req  output  1  data memory access request.
halted  output  1  FSM in HALT.
illegal_op  output  1  sticky, illegal opcode seen.
mem_timeout  output  1  sticky, MEM wait exceeded MEM_TIMEOUT.
instr_count  output  CNT_W  instructions retired, saturating.

Behaviour:
- Opcodes: 0 ADD, 1 XOR, 2 AND, 3 RSL, 4 MOV, 5 LD, 6 ST, 7 HLT, >=8 illegal (executed as NOP).
- Reset (async, any state, mid-instruction included): state=IDLE, op_q=0, wait counter=0, instr_count=0, illegal_op=0, mem_timeout=0. All strobes and halted read 0.
- State register: IDLE, FETCH, DECODE, MEM, WB, HALT. op_q is a flop.
- Strobes are decoded from state and op_q only, and are therefore glitch-free. Exception: immediate in DECODE uses the live instructions input.
- IDLE: all strobes 0. Next state is FETCH if run=1, else IDLE.
- FETCH: next_ins=1 for exactly 1 cycle. Next state is DECODE.
- DECODE: op_q <= instructions at the exit edge; immediate = (instructions==MOV). Next state:
  - LD/ST: MEM.
  - HLT: HALT.
  - Otherwise (legal or illegal): WB.
  - Illegal opcode also sets illegal_op=1 on the exit edge.
- MEM: mem_req=1; mem_write=(op_q==ST); mem_to_reg=(op_q==LD).
  - The wait counter increments each MEM cycle with mem_ready=0.
  - mem_ready=1: next state WB, counter cleared.
  - MEM_TIMEOUT>0 and counter==MEM_TIMEOUT with mem_ready=0: set mem_timeout, next state HALT.
  - mem_ready and timeout in the same cycle: mem_ready wins.
  - Minimum MEM dwell is 1 cycle.
- WB:
  - reg_write=1 for op_q in {0..4, LD}; reg_write=0 for ST and illegal.
  - immediate=(op_q==MOV); mem_to_reg=(op_q==LD).
  - instr_count increments on the exit edge and saturates at all-ones.
  - Next state is FETCH if run=1, else IDLE.
- HALT: halted=1, all strobes 0. Only reset leaves HALT; HLT does not count as retired.
- Latency: ALU/MOV = 3 cycles (FETCH, DECODE, WB). LD/ST = 4 + extra mem_ready wait cycles.
- alu_op = op_q at all times. It updates on the DECODE exit edge, so it is stable through MEM and WB.

Test Plan:
- Reset, run=1, program ADD,MOV,XOR with instantaneous opcodes -> next_ins pulses at cycles 1,4,7. reg_write=1 in each WB. immediate=1 in MOV's DECODE and WB only. instr_count=3.
- LD with mem_ready asserted 3 cycles after MEM entry -> mem_req high 4 cycles, mem_to_reg high in MEM and WB, reg_write=1 in WB only, total 7 cycles.
- ST, MEM_TIMEOUT=4, mem_ready never -> mem_write high 5 cycles, then halted=1, mem_timeout=1, instr_count unchanged. Only reset exits.
- OP_W=4, opcode 9 -> illegal_op=1 after DECODE, WB with reg_write=0, instr_count+1, execution continues. HLT next -> halted=1.
- run dropped during an LD's MEM -> LD completes WB, FSM parks in IDLE with all strobes 0. run=1 again -> FETCH next cycle.
- Assert reset mid-MEM (async, between edges) -> outputs clear immediately, instr_count=0, sticky flags cleared, restart from IDLE.
